rr_arb4: RTL and testbench

RR_ARB4 -- requirements
Module: rr_arb4

---
 rtl/rr_arb4_if.sv | 13 +
 rtl/rr_arb4.sv | 130 +++++++++++++
 tb/tb_rr_arb4.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rr_arb4_if.sv
// Handshake bundle between four requesters and the round-robin arbiter.
// Requesters drive en/req, and the arbiter returns the registered grant outputs.
interface rr_arb4_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       to_pulse;

  modport master (output en, req, input gnt, gnt_id, gnt_vld, to_pulse);
  modport slave  (input en, req, output gnt, gnt_id, gnt_vld, to_pulse);
endinterface

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with a one-cycle registered grant. An owner keeps the grant until it drops req.
// A grant always passes through IDLE. Optional hold timeout under RR_ARB4_TIMEOUT_EN.
module rr_arb4 #(
  parameter int HOLD_MAX = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  rr_arb4_if.slave bus
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_arb4: HOLD_MAX out of range 2..255");
  end

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] id_q, id_d;
  logic [1:0] last_q, last_d;
  logic       hold_expired;
  logic       revoke;
  logic [3:0] gnt_q, gnt_d;
  logic       vld_q, vld_d;
  logic       pulse_d;

  // Rotated search: the first set bit at last+1, last+2, last+3, last+4 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef RR_ARB4_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  assign hold_expired = (hold_q == 8'(HOLD_MAX - 1));
  // The counter clears on any cycle that does not continue the current ownership.
  assign hold_d = (state_q == OWN && state_d == OWN) ? hold_q + 8'd1 : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 8'd0;
    else        hold_q <= hold_d;
  end
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= 2'b00;
      last_q  <= 2'b11;
      gnt_q   <= 4'b0000;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    revoke  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && (bus.req != 4'b0000)) begin
          state_d = OWN;
          id_d    = rr_pick(last_q, bus.req);
        end
      end
      OWN: begin
        // A voluntary release wins over a timeout that expires on the same edge.
        if (!bus.req[id_q]) begin
          state_d = IDLE;
          last_d  = id_q;
        end else if (hold_expired) begin
          state_d = IDLE;
          last_d  = id_q;
          revoke  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = 4'b0000;
    vld_d   = 1'b0;
    pulse_d = revoke;
    if (state_d == OWN) begin
      gnt_d = 4'b0001 << id_d;
      vld_d = 1'b1;
    end
  end

`ifdef RR_ARB4_TIMEOUT_EN
  logic pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse_q <= 1'b0;
    else        pulse_q <= pulse_d;
  end

  assign bus.to_pulse = pulse_q;
`else
  logic unused_pulse;
  assign unused_pulse = pulse_d;
  assign bus.to_pulse = 1'b0;
`endif

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = vld_q;
  assign bus.gnt_id  = id_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Directed bench for rr_arb4. A behavioural owner/last/held model is checked every cycle.
// Literal expectations pin the model, and the timeout scenario is selected by RR_ARB4_TIMEOUT_EN.
module tb_rr_arb4;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  rr_arb4_if bus();

  rr_arb4 #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: owner index or -1, last served index, cycles the grant has been visible.
  int m_owner = -1;
  int m_last = 3;
  int m_held = 0;
  bit m_pulse = 1'b0;
  bit model_on = 1'b1;

  function automatic void model_next(input int own, input int last, input int held,
                                     input logic en_i, input logic [3:0] r,
                                     output int n_own, output int n_last,
                                     output int n_held, output bit n_pulse);
    bit timeout_on;
`ifdef RR_ARB4_TIMEOUT_EN
    timeout_on = 1'b1;
`else
    timeout_on = 1'b0;
`endif
    n_own = own; n_last = last; n_held = held; n_pulse = 1'b0;
    if (own < 0) begin
      if (en_i && r != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (n_own < 0 && r[(last + k) % 4]) n_own = (last + k) % 4;
        end
        n_held = 1;
      end
    end else if (!r[own]) begin
      n_own = -1; n_last = own;
    end else if (timeout_on && held == HOLD) begin
      n_own = -1; n_last = own; n_pulse = 1'b1;
    end else begin
      n_held = held + 1;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int no, nl, nh;
    bit np;
    if (!rst_n) begin
      m_owner <= -1; m_last <= 3; m_held <= 0; m_pulse <= 1'b0;
    end else begin
      model_next(m_owner, m_last, m_held, bus.en, bus.req, no, nl, nh, np);
      m_owner <= no; m_last <= nl; m_held <= nh; m_pulse <= np;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("model_gnt", 32'(bus.gnt), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
      chk("model_vld", 32'(bus.gnt_vld), 32'(m_owner >= 0));
      if (m_owner >= 0) chk("model_gnt_id", 32'(bus.gnt_id), 32'(m_owner));
      chk("model_to_pulse", 32'(bus.to_pulse), 32'(m_pulse));
      chk("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
      chk("vld_consistent", 32'(bus.gnt_vld), 32'(bus.gnt != 4'b0000));
    end
  end

  task automatic do_reset(input logic en_v, input logic [3:0] req_v);
    rst_n = 1'b0; bus.en = 1'b0; bus.req = 4'b0000;
    repeat (2) @(negedge clk);
    bus.en = en_v; bus.req = req_v; rst_n = 1'b1;
  endtask

  task automatic exp_gnt(input string nm, input logic [3:0] g);
    @(negedge clk);
    chk(nm, 32'(bus.gnt), 32'(g));
  endtask

  initial begin
    bus.en = 1'b0; bus.req = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_vld", 32'(bus.gnt_vld), 32'd0);
    chk("rst_id", 32'(bus.gnt_id), 32'd0);
    chk("rst_pulse", 32'(bus.to_pulse), 32'd0);

    // Basic grant after reset: requester 0 first, then 1 via an idle cycle.
    do_reset(1'b1, 4'b1111);
    exp_gnt("first_gnt", 4'b0001);
    bus.req = 4'b1110;
    exp_gnt("release_idle", 4'b0000);
    exp_gnt("next_owner1", 4'b0010);
    chk("next_owner1_id", 32'(bus.gnt_id), 32'd1);

    // Full rotation with each owner holding for two cycles.
    do_reset(1'b1, 4'b1111);
    for (int k = 0; k < 5; k++) begin
      exp_gnt($sformatf("rot%0d_c1", k), 4'(1 << (k % 4)));
      exp_gnt($sformatf("rot%0d_c2", k), 4'(1 << (k % 4)));
      bus.req = 4'b1111 & ~4'(1 << (k % 4));
      exp_gnt($sformatf("rot%0d_idle", k), 4'b0000);
      bus.req = 4'b1111;
    end

    // No preemption, and en low neither revokes nor allows a new grant.
    do_reset(1'b1, 4'b0100);
    exp_gnt("own2", 4'b0100);
    bus.req = 4'b0101; bus.en = 1'b0;
    repeat (3) exp_gnt("own2_hold", 4'b0100);
    bus.req = 4'b0001;
    repeat (3) exp_gnt("en0_idle", 4'b0000);
    bus.en = 1'b1;
    exp_gnt("en1_grant0", 4'b0001);

    // Rotated priority from last=1 picks 3 ahead of 0.
    do_reset(1'b1, 4'b0010);
    exp_gnt("own1", 4'b0010);
    bus.req = 4'b0000;
    exp_gnt("own1_rel", 4'b0000);
    bus.req = 4'b1001;
    exp_gnt("rot_pick3", 4'b1000);
    chk("rot_pick3_id", 32'(bus.gnt_id), 32'd3);

    // A re-requesting previous owner has the lowest priority.
    do_reset(1'b1, 4'b0001);
    exp_gnt("own0", 4'b0001);
    bus.req = 4'b0010;
    exp_gnt("own0_rel", 4'b0000);
    bus.req = 4'b0011;
    exp_gnt("rereq_loses", 4'b0010);

    // Reset asserted between edges drops the grant at once.
    do_reset(1'b1, 4'b1000);
    exp_gnt("own3", 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("async_rst_vld", 32'(bus.gnt_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.req = 4'b1000; bus.en = 1'b1;
    exp_gnt("post_rst_own3", 4'b1000);

`ifdef RR_ARB4_TIMEOUT_EN
    do_reset(1'b1, 4'b0011);
    for (int k = 0; k < HOLD; k++) exp_gnt($sformatf("to_hold%0d", k), 4'b0001);
    exp_gnt("to_revoke", 4'b0000);
    chk("to_pulse_hi", 32'(bus.to_pulse), 32'd1);
    exp_gnt("to_next1", 4'b0010);
    chk("to_pulse_lo", 32'(bus.to_pulse), 32'd0);
`else
    do_reset(1'b1, 4'b0011);
    repeat (20) exp_gnt("no_timeout_hold", 4'b0001);
    chk("no_timeout_pulse", 32'(bus.to_pulse), 32'd0);
`endif

    @(negedge clk);
    model_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
